// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; result is {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and retires in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_div
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_lat, b_lat, quo, dvs, rem;
  logic             sgn;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_mag, b_mag, rem_nxt, quo_nxt, q_fix, r_fix;
  logic [WIDTH:0]   shifted;
  logic             ge, last, accept;
  logic [2*WIDTH-1:0] final_res;

  assign accept = start & ~annul;
  assign a_mag  = (signed_div & a[WIDTH-1]) ? -a : a;
  assign b_mag  = (signed_div & b[WIDTH-1]) ? -b : b;

  // Partial remainder is shifted into WIDTH+1 bits so the compare never overflows;
  // the difference always fits back into WIDTH bits.
  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvs);
  assign rem_nxt = ge ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ge};
  assign last    = (cnt == CW'(WIDTH-1));

  assign q_fix     = (sgn & (a_lat[WIDTH-1] ^ b_lat[WIDTH-1])) ? -quo_nxt : quo_nxt;
  assign r_fix     = (sgn & a_lat[WIDTH-1]) ? -rem_nxt : rem_nxt;
  assign final_res = (b_lat == '0) ? {a_lat, {WIDTH{1'b1}}} : {r_fix, q_fix};

  assign ready = (state == DONE);

  always_comb begin
    state_nxt = state;
    stall_div = 1'b0;
    case (state)
      IDLE: if (accept) begin
        stall_div = 1'b1;
`ifdef DIV_ZERO_FAST_EN
        state_nxt = (b == '0) ? DONE : CALC;
`else
        state_nxt = CALC;
`endif
      end
      CALC: begin
        stall_div = 1'b1;
        if (annul)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      cnt    <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      sgn    <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          a_lat <= a;
          b_lat <= b;
          sgn   <= signed_div;
          quo   <= a_mag;
          dvs   <= b_mag;
          rem   <= '0;
          cnt   <= '0;
`ifdef DIV_ZERO_FAST_EN
          if (b == '0) result <= {a, {WIDTH{1'b1}}};
`endif
        end
        CALC: if (!annul) begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (last) result <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, stall length, signed/unsigned results,
// divide-by-zero, annul, mid-operation reset and back-to-back issue.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        ready, stall_div;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .a(a), .b(b), .result(result), .ready(ready), .stall_div(stall_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge (cycle 0), hold start until ready, report
  // the ready cycle (-1 on timeout) and the number of cycles with stall_div high.
  task automatic run_op(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                        output int rcyc, output int scnt);
    @(negedge clk);
    start = 1'b1; signed_div = sd; a = av; b = bv; annul = 1'b0;
    rcyc = -1; scnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (stall_div) scnt++;
      if (ready) begin rcyc = c; break; end
    end
    start = 1'b0;
  endtask

  int rc, sc, rc2, sc2, nrdy;
  int zlat;

  initial begin
`ifdef DIV_ZERO_FAST_EN
    zlat = 1;
`else
    zlat = 33;
`endif
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_result", result, 64'h0);
    chk("rst_ready", {63'h0, ready}, 64'h0);
    chk("rst_stall", {63'h0, stall_div}, 64'h0);
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, rc, sc);
    chk("divu_res", result, {32'h2, 32'hE});
    chk("divu_lat", 64'(rc), 64'd33);
    chk("divu_stall", 64'(sc), 64'd33);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, rc, sc);
    chk("div_neg_res", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("div_neg_lat", 64'(rc), 64'd33);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rc, sc);
    chk("div_ovf_res", result, {32'h0, 32'h8000_0000});

    run_op(1'b1, 32'h1234_5678, 32'h0, rc, sc);
    chk("div0_res", result, {32'h1234_5678, 32'hFFFF_FFFF});
    chk("div0_lat", 64'(rc), 64'(zlat));
    chk("div0_stall", 64'(sc), 64'(zlat));

    // annul in CALC iteration 10
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) annul = 1'b1;
    end
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("annul_stall", {63'h0, stall_div}, 64'h0);
    chk("annul_ready", {63'h0, ready}, 64'h0);
    chk("annul_result", result, {32'h1234_5678, 32'hFFFF_FFFF});
    nrdy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (ready) nrdy++;
    end
    chk("annul_noready", 64'(nrdy), 64'd0);

    run_op(1'b0, 32'd9, 32'd3, rc, sc);
    chk("after_annul_res", result, {32'h0, 32'h3});
    chk("after_annul_lat", 64'(rc), 64'd33);

    // reset in CALC
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; a = 32'd77; b = 32'd5;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_result", result, 64'h0);
    chk("midrst_ready", {63'h0, ready}, 64'h0);
    chk("midrst_stall", {63'h0, stall_div}, 64'h0);
    rst = 1'b0;

    // back-to-back: second request in the IDLE cycle right after DONE
    run_op(1'b0, 32'd50, 32'd5, rc, sc);
    chk("b2b1_res", result, {32'h0, 32'd10});
    chk("b2b1_lat", 64'(rc), 64'd33);
    run_op(1'b0, 32'd7, 32'h10, rc2, sc2);
    chk("b2b2_res", result, {32'd7, 32'h0});
    chk("b2b2_lat", 64'(rc + 1 + rc2), 64'd67);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
